// File: rtl/vga_pkg.sv
// Package shared by the frame-buffer arbiter and the VGA timing counters.
//   H_VISIBLE / V_VISIBLE : visible raster size
//   FB_DEPTH              : number of pixels in one frame
//   op_e                  : RAM operation selected for the next cycle
package vga_pkg;

  localparam logic [10:0] H_VISIBLE = 11'd1024;
  localparam logic [10:0] V_VISIBLE = 11'd768;
  localparam int          FB_DEPTH  = int'(H_VISIBLE) * int'(V_VISIBLE);

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Linear frame-buffer address generator (combinational).
//   pix_x, pix_y : pixel column / line
//   addr         : pix_y * H_VISIBLE + pix_x, ADDR_W bits
//   in_range     : 1 when the pixel lies inside the visible raster
module fb_addr_gen #(
  parameter logic [10:0] H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter logic [10:0] V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int          ADDR_W    = 20
) (
  input  logic [10:0]       pix_x,
  input  logic [10:0]       pix_y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  localparam int H_INT   = int'(H_VISIBLE);
  localparam bit H_POW2  = ((H_INT & (H_INT - 1)) == 0);
  localparam int H_SHIFT = $clog2(H_INT);

  // A power-of-two line length turns the multiply into plain wiring.
  if (H_POW2) begin : g_shift
    assign addr = (ADDR_W'(pix_y) << H_SHIFT) + ADDR_W'(pix_x);
  end else begin : g_mult
    assign addr = ADDR_W'(pix_y) * ADDR_W'(H_VISIBLE) + ADDR_W'(pix_x);
  end

  assign in_range = (pix_x < H_VISIBLE) && (pix_y < V_VISIBLE);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: VGA scanout reads always win, draw-engine
// writes use only cycles without a pixel request (optionally blanking only).
//   slow_clock, reset          : pixel clock, synchronous active-high reset
//   display_enable             : visible-area flag from the timing counters
//   pix_req, pix_x, pix_y      : scanout fetch request and coordinates
//   pix_data, pix_valid        : fetched pixel, MEM_LAT+2 cycles after pix_req
//   wr_valid/wr_ready/wr_addr/wr_data : draw-engine write handshake
//   mem_en/mem_we/mem_addr/mem_wdata  : registered RAM command
//   mem_rdata                  : RAM read data, MEM_LAT cycles after a read
//   range_err                  : sticky out-of-range access flag
module vga_fb_arbiter #(
  parameter logic [10:0]       H_VISIBLE     = vga_pkg::H_VISIBLE,
  parameter logic [10:0]       V_VISIBLE     = vga_pkg::V_VISIBLE,
  parameter int                ADDR_W        = 20,
  parameter int                DATA_W        = 8,
  parameter int                MEM_LAT       = 1,
  parameter bit                BLANK_ONLY_WR = 1'b1,
  parameter logic [DATA_W-1:0] BORDER_COLOR  = '0
) (
  input  logic              slow_clock,
  input  logic              reset,
  input  logic              display_enable,
  input  logic              pix_req,
  input  logic [10:0]       pix_x,
  input  logic [10:0]       pix_y,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              range_err
);

  import vga_pkg::*;

  localparam int                FB_DEPTH_P = int'(H_VISIBLE) * int'(V_VISIBLE);
  localparam logic [ADDR_W:0]   FB_LIMIT   = (ADDR_W + 1)'(FB_DEPTH_P);

  if ($clog2(FB_DEPTH_P) > ADDR_W) begin : g_addr_w_chk
    $error("vga_fb_arbiter: ADDR_W too narrow for the frame buffer");
  end
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_chk
    $error("vga_fb_arbiter: MEM_LAT must be 1..4");
  end

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;
  logic              wr_fire;
  logic              wr_in_range;
  op_e               op_q;
  // Read-tag pipeline: request seen / border pixel, one entry per cycle.
  logic [MEM_LAT:0]  vld_p;
  logic [MEM_LAT:0]  brd_p;

  fb_addr_gen #(
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .addr     (rd_addr),
    .in_range (rd_in_range)
  );

  assign wr_ready    = !reset && !pix_req && (!BLANK_ONLY_WR || !display_enable);
  assign wr_fire     = wr_valid && wr_ready;
  // Extra MSB keeps the limit exact even when FB_DEPTH == 2**ADDR_W.
  assign wr_in_range = ({1'b0, wr_addr} < FB_LIMIT);

  assign mem_en = (op_q != OP_IDLE);
  assign mem_we = (op_q == OP_WRITE);

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      op_q      <= OP_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      range_err <= 1'b0;
      vld_p     <= '0;
      brd_p     <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      // Stage p0: arbitrate and issue the RAM command.
      op_q <= OP_IDLE;
      if (pix_req) begin
        if (rd_in_range) begin
          op_q     <= OP_READ;
          mem_addr <= rd_addr;
        end else begin
          range_err <= 1'b1;
        end
      end else if (wr_fire) begin
        // Out-of-range writes complete the handshake but never reach the RAM.
        if (wr_in_range) begin
          op_q      <= OP_WRITE;
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end else begin
          range_err <= 1'b1;
        end
      end

      // Stages p1..pMEM_LAT: tags ride alongside the RAM latency.
      vld_p <= {vld_p[MEM_LAT-1:0], pix_req};
      brd_p <= {brd_p[MEM_LAT-1:0], pix_req && !rd_in_range};

      // Final stage: capture the returned pixel or substitute the border.
      pix_valid <= vld_p[MEM_LAT];
      if (vld_p[MEM_LAT]) begin
        pix_data <= brd_p[MEM_LAT] ? BORDER_COLOR : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter (1024x768, MEM_LAT=1, blank-only writes).
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam int OVL    = 4096;
  localparam int DEPTH  = 1024 * 768;

  typedef struct {
    bit         v;
    logic [7:0] d;
  } pent_t;

  logic              slow_clock = 1'b0;
  logic              reset, display_enable, pix_req, wr_valid;
  logic [10:0]       pix_x, pix_y;
  logic [DATA_W-1:0] pix_data, wr_data, mem_wdata, mem_rdata;
  logic              pix_valid, wr_ready, mem_en, mem_we, range_err;
  logic [ADDR_W-1:0] wr_addr, mem_addr;

  int n_cmp = 0;
  int n_err = 0;

  // RAM model: fixed pattern everywhere, overlay for the low 4K words.
  logic             ram_clear;
  logic [7:0]       ovl [0:OVL-1];
  logic [OVL-1:0]   wrote;
  logic [7:0]       shadow [int];

  always #5 slow_clock = ~slow_clock;

  vga_fb_arbiter #(
    .H_VISIBLE(11'd1024), .V_VISIBLE(11'd768), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_LAT(1), .BLANK_ONLY_WR(1'b1), .BORDER_COLOR(8'h00)
  ) dut (
    .slow_clock(slow_clock), .reset(reset), .display_enable(display_enable),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .range_err(range_err)
  );

  function automatic logic [7:0] pattern(int a);
    return 8'((a * 37) ^ (a >> 7) ^ 8'h5A);
  endfunction

  function automatic logic [7:0] ram_word(logic [ADDR_W-1:0] a);
    if (a < ADDR_W'(OVL) && wrote[a[11:0]]) return ovl[a[11:0]];
    return pattern(int'(a));
  endfunction

  // Expected frame-buffer content from the bench's own record of writes.
  function automatic logic [7:0] exp_pix(int a);
    if (shadow.exists(a)) return shadow[a];
    return pattern(a);
  endfunction

  always @(posedge slow_clock) begin
    if (ram_clear) begin
      wrote <= '0;
    end else if (mem_en && mem_we && mem_addr < ADDR_W'(OVL)) begin
      ovl[mem_addr[11:0]]   <= mem_wdata;
      wrote[mem_addr[11:0]] <= 1'b1;
    end
    if (mem_en && !mem_we) mem_rdata <= ram_word(mem_addr);
  end

  task automatic idle_inputs();
    display_enable = 1'b0; pix_req = 1'b0; pix_x = '0; pix_y = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic apply_reset();
    @(negedge slow_clock);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge slow_clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge slow_clock);
    reset = 1'b1; display_enable = 1'b0; wr_valid = 1'b1; wr_addr = 20'd5;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready);
    end
    @(negedge slow_clock);
    n_cmp++;
    if ({pix_valid, pix_data, mem_en, mem_we, mem_addr, mem_wdata, range_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h en=%b we=%b a=%0d wd=%h re=%b want all 0",
               pix_valid, pix_data, mem_en, mem_we, mem_addr, mem_wdata, range_err);
    end
    wr_valid = 1'b0; reset = 1'b0;
  endtask

  task automatic test_read_basic();
    apply_reset();
    display_enable = 1'b0; wr_valid = 1'b1; wr_addr = 20'd2053; wr_data = 8'hA5;
    shadow[2053] = 8'hA5;
    @(negedge slow_clock); wr_valid = 1'b0;
    @(negedge slow_clock);
    pix_req = 1'b1; pix_x = 11'd5; pix_y = 11'd2;
    @(negedge slow_clock); pix_req = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 20'd2053) begin
      n_err++; $display("FAIL read_cmd: got en=%b we=%b a=%0d want 1 0 2053", mem_en, mem_we, mem_addr);
    end
    @(negedge slow_clock);
    n_cmp++;
    if (pix_valid !== 1'b0 || mem_en !== 1'b0) begin
      n_err++; $display("FAIL read_t2: got v=%b en=%b want 0 0", pix_valid, mem_en);
    end
    @(negedge slow_clock);
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== 8'hA5) begin
      n_err++; $display("FAIL read_data: got v=%b d=%h want 1 a5", pix_valid, pix_data);
    end
    @(negedge slow_clock);
    n_cmp++;
    if (pix_valid !== 1'b0) begin
      n_err++; $display("FAIL read_t4: got v=%b want 0", pix_valid);
    end
  endtask

  task automatic test_back_to_back();
    int  got;
    bit  wr_seen;
    bit  ev;
    int  j;
    got = 0; wr_seen = 1'b0;
    apply_reset();
    display_enable = 1'b0; wr_valid = 1'b1; wr_addr = 20'd10; wr_data = 8'hEE;
    for (int i = 0; i < 1027; i++) begin
      if (i < 1024) begin
        pix_req = 1'b1; pix_x = 11'(i); pix_y = 11'd5;
      end else begin
        pix_req = 1'b0; wr_valid = 1'b0;
      end
      #1;
      if (i < 1024) begin
        n_cmp++;
        if (wr_ready !== 1'b0) begin
          n_err++; $display("FAIL b2b_wr_ready: cycle %0d got %b want 0", i, wr_ready);
        end
      end
      @(negedge slow_clock);
      if (mem_en === 1'b1 && mem_we === 1'b1) wr_seen = 1'b1;
      if (i < 1024) begin
        n_cmp++;
        if (mem_en !== 1'b1 || mem_addr !== ADDR_W'(5 * 1024 + i)) begin
          n_err++; $display("FAIL b2b_addr: cycle %0d got en=%b a=%0d want 1 %0d", i, mem_en, mem_addr, 5 * 1024 + i);
        end
      end
      j  = i - 2;
      ev = (j >= 0 && j < 1024);
      if (pix_valid === 1'b1) got++;
      n_cmp++;
      if (pix_valid !== ev || (ev && pix_data !== exp_pix(5 * 1024 + j))) begin
        n_err++;
        $display("FAIL b2b_pixel: idx %0d got v=%b d=%h want v=%b d=%h", j, pix_valid, pix_data, ev,
                 ev ? exp_pix(5 * 1024 + j) : 8'h00);
      end
    end
    n_cmp++;
    if (got != 1024 || wr_seen) begin
      n_err++; $display("FAIL b2b_totals: got %0d pixels writes=%b want 1024 0", got, wr_seen);
    end
  endtask

  task automatic test_write();
    apply_reset();
    display_enable = 1'b0; wr_valid = 1'b1; wr_addr = 20'd100; wr_data = 8'h3C;
    shadow[100] = 8'h3C;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_ready_blank: got %b want 1", wr_ready);
    end
    @(negedge slow_clock);
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 20'd100, 8'h3C}) begin
      n_err++; $display("FAIL write_cmd: got en=%b we=%b a=%0d wd=%h want 1 1 100 3c", mem_en, mem_we, mem_addr, mem_wdata);
    end
    display_enable = 1'b1; wr_addr = 20'd200; wr_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (wr_ready !== 1'b0) begin
        n_err++; $display("FAIL wr_stall_ready: cycle %0d got %b want 0", i, wr_ready);
      end
      @(negedge slow_clock);
      n_cmp++;
      if (mem_en !== 1'b0 || mem_addr !== 20'd100 || mem_wdata !== 8'h3C) begin
        n_err++; $display("FAIL wr_stall_hold: got en=%b a=%0d wd=%h want 0 100 3c", mem_en, mem_addr, mem_wdata);
      end
    end
    display_enable = 1'b0;
    shadow[200] = 8'h77;
    @(negedge slow_clock); wr_valid = 1'b0;
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 20'd200, 8'h77}) begin
      n_err++; $display("FAIL write_resume: got en=%b we=%b a=%0d wd=%h want 1 1 200 77", mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge slow_clock);
    n_cmp++;
    if (mem_en !== 1'b0) begin
      n_err++; $display("FAIL write_idle: got en=%b want 0", mem_en);
    end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    pix_req = 1'b1; pix_x = 11'd1024; pix_y = 11'd0;
    @(negedge slow_clock); pix_req = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b0 || range_err !== 1'b1) begin
      n_err++; $display("FAIL oor_x_cmd: got en=%b re=%b want 0 1", mem_en, range_err);
    end
    @(negedge slow_clock);
    @(negedge slow_clock);
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== 8'h00) begin
      n_err++; $display("FAIL oor_x_pixel: got v=%b d=%h want 1 00", pix_valid, pix_data);
    end
    // Last visible pixel is still a real read.
    pix_req = 1'b1; pix_x = 11'd1023; pix_y = 11'd767;
    @(negedge slow_clock);
    pix_x = 11'd3; pix_y = 11'd768;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_addr !== 20'd786431) begin
      n_err++; $display("FAIL last_pix_cmd: got en=%b a=%0d want 1 786431", mem_en, mem_addr);
    end
    @(negedge slow_clock); pix_req = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b0) begin
      n_err++; $display("FAIL oor_y_cmd: got en=%b want 0", mem_en);
    end
    @(negedge slow_clock);
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== exp_pix(786431)) begin
      n_err++; $display("FAIL last_pix_data: got v=%b d=%h want 1 %h", pix_valid, pix_data, exp_pix(786431));
    end
    @(negedge slow_clock);
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== 8'h00) begin
      n_err++; $display("FAIL oor_y_pixel: got v=%b d=%h want 1 00", pix_valid, pix_data);
    end
    apply_reset();
    n_cmp++;
    if (range_err !== 1'b0) begin
      n_err++; $display("FAIL oor_reset_clear: got %b want 0", range_err);
    end
    display_enable = 1'b0; wr_valid = 1'b1; wr_addr = 20'd786432; wr_data = 8'h11;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++; $display("FAIL oor_wr_ready: got %b want 1", wr_ready);
    end
    @(negedge slow_clock); wr_valid = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b0 || range_err !== 1'b1) begin
      n_err++; $display("FAIL oor_wr_drop: got en=%b re=%b want 0 1", mem_en, range_err);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    display_enable = 1'b0; wr_valid = 1'b1; wr_addr = 20'hFFFFF; wr_data = 8'h22;
    @(negedge slow_clock); wr_valid = 1'b0;
    pix_req = 1'b1; pix_x = 11'd9; pix_y = 11'd1;
    @(negedge slow_clock);
    pix_req = 1'b0; reset = 1'b1; wr_valid = 1'b1; wr_addr = 20'd50;
    n_cmp++;
    if (mem_en !== 1'b1 || range_err !== 1'b1) begin
      n_err++; $display("FAIL mid_setup: got en=%b re=%b want 1 1", mem_en, range_err);
    end
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_wr_ready: got %b want 0", wr_ready);
    end
    @(negedge slow_clock);
    n_cmp++;
    if ({pix_valid, pix_data, mem_en, mem_we, mem_addr, mem_wdata, range_err} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got v=%b d=%h en=%b we=%b a=%0d wd=%h re=%b want all 0",
               pix_valid, pix_data, mem_en, mem_we, mem_addr, mem_wdata, range_err);
    end
    reset = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge slow_clock);
      n_cmp++;
      if (pix_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_no_pixel: cycle %0d got v=%b want 0", i, pix_valid);
      end
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    display_enable = 1'b0;
    pix_req = 1'b1; pix_x = 11'd7; pix_y = 11'd1;
    wr_valid = 1'b1; wr_addr = 20'd300; wr_data = 8'h99;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_err++; $display("FAIL same_ready0: got %b want 0", wr_ready);
    end
    @(negedge slow_clock);
    pix_x = 11'd8;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 20'd1031) begin
      n_err++; $display("FAIL same_read0: got en=%b we=%b a=%0d want 1 0 1031", mem_en, mem_we, mem_addr);
    end
    @(negedge slow_clock);
    pix_req = 1'b0;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 20'd1032) begin
      n_err++; $display("FAIL same_read1: got en=%b we=%b a=%0d want 1 0 1032", mem_en, mem_we, mem_addr);
    end
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++; $display("FAIL same_ready1: got %b want 1", wr_ready);
    end
    shadow[300] = 8'h99;
    @(negedge slow_clock);
    wr_valid = 1'b0;
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 20'd300, 8'h99}) begin
      n_err++; $display("FAIL same_write: got en=%b we=%b a=%0d wd=%h want 1 1 300 99", mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== exp_pix(1031)) begin
      n_err++; $display("FAIL same_pix0: got v=%b d=%h want 1 %h", pix_valid, pix_data, exp_pix(1031));
    end
    @(negedge slow_clock);
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== exp_pix(1032)) begin
      n_err++; $display("FAIL same_pix1: got v=%b d=%h want 1 %h", pix_valid, pix_data, exp_pix(1032));
    end
  endtask

  // Random traffic against a transaction-level model: each cycle's request
  // predicts the next-cycle RAM command and a pixel three cycles later.
  task automatic test_random();
    pent_t             q[$];
    pent_t             ent;
    pent_t             e;
    bit                e_en, e_we, e_rerr, pr, de, rdy, fire;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_wdata;
    logic [10:0]       x, y;
    int                a;
    apply_reset();
    e_en = 1'b0; e_we = 1'b0; e_rerr = 1'b0; e_addr = '0; e_wdata = '0;
    ent.v = 1'b0; ent.d = 8'h00;
    repeat (3) q.push_back(ent);
    for (int k = 0; k < 3000; k++) begin
      e = q.pop_front();
      n_cmp++;
      if (mem_en !== e_en || mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        n_err++;
        $display("FAIL rnd_mem: cycle %0d got en=%b we=%b a=%0d wd=%h want %b %b %0d %h",
                 k, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      end
      n_cmp++;
      if (pix_valid !== e.v || (e.v && pix_data !== e.d)) begin
        n_err++; $display("FAIL rnd_pixel: cycle %0d got v=%b d=%h want v=%b d=%h", k, pix_valid, pix_data, e.v, e.d);
      end
      n_cmp++;
      if (range_err !== e_rerr) begin
        n_err++; $display("FAIL rnd_range_err: cycle %0d got %b want %b", k, range_err, e_rerr);
      end
      pr = ($urandom_range(0, 9) < 6);
      x  = ($urandom_range(0, 19) == 0) ? 11'($urandom_range(1024, 2047)) : 11'($urandom_range(0, 1023));
      y  = ($urandom_range(0, 19) == 0) ? 11'($urandom_range(768, 2047)) : 11'($urandom_range(0, 3));
      de = ($urandom_range(0, 3) == 0);
      if (!wr_valid && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b1;
        wr_addr  = ($urandom_range(0, 9) == 0) ? 20'($urandom_range(DEPTH, 1048575)) : 20'($urandom_range(0, OVL - 1));
        wr_data  = 8'($urandom);
      end
      pix_req = pr; pix_x = x; pix_y = y; display_enable = de;
      #1;
      rdy = !pr && !de;
      n_cmp++;
      if (wr_ready !== rdy) begin
        n_err++; $display("FAIL rnd_wr_ready: cycle %0d got %b want %b", k, wr_ready, rdy);
      end
      e_en = 1'b0; e_we = 1'b0; fire = 1'b0;
      if (pr) begin
        ent.v = 1'b1;
        if (x < 11'd1024 && y < 11'd768) begin
          a = int'(y) * 1024 + int'(x);
          e_en = 1'b1; e_addr = ADDR_W'(a);
          ent.d = exp_pix(a);
        end else begin
          e_rerr = 1'b1;
          ent.d = 8'h00;
        end
      end else begin
        ent.v = 1'b0; ent.d = 8'h00;
        if (wr_valid && rdy) begin
          fire = 1'b1;
          if (int'(wr_addr) < DEPTH) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = wr_addr; e_wdata = wr_data;
            shadow[int'(wr_addr)] = wr_data;
          end else begin
            e_rerr = 1'b1;
          end
        end
      end
      q.push_back(ent);
      @(negedge slow_clock);
      if (fire) wr_valid = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ram_clear = 1'b1;
    reset     = 1'b1;
    idle_inputs();
    repeat (2) @(negedge slow_clock);
    ram_clear = 1'b0;
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_write();
    test_out_of_range();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
